// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive core.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartChk,
    StData,
    StStopChk,
    StLoad
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial line and read handshake in, byte and status flags out.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;

  modport master (
    output serial_in,
    output data_read,
    input  rx_data,
    input  data_ready,
    input  overrun_error,
    input  framing_error
  );

  modport slave (
    input  serial_in,
    input  data_read,
    output rx_data,
    output data_ready,
    output overrun_error,
    output framing_error
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period timer: strobes at mid-bit of every bit in a frame and tracks the bit index.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  localparam int unsigned IDX_W       = $clog2(DATA_BITS + 2)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             restart,
  output logic             sample_strobe,
  output logic [IDX_W-1:0] bit_index
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  // Preload so the first wrap (start-bit sample) falls HALF cycles after the start edge.
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign sample_strobe = enable && (cnt_q == CNT_MAX);
  assign bit_index     = idx_q;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (restart) begin
      cnt_d = CNT_FIRST;
      idx_d = '0;
    end else if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (sample_strobe) begin
      cnt_d = '0;
      if (idx_q != IDX_MAX) idx_d = idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: start detection, mid-bit sampling, LSB-first shift, stop check and
// byte hand-off with overrun / framing status.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input logic     clk,
  input logic     n_rst,
  uart_rx_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 2);

  rx_state_e            state_q, state_d;
  logic                 hist_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;

  logic             start_edge;
  logic             timer_en;
  logic             strobe;
  logic [IDX_W-1:0] bit_index;

  assign start_edge = (state_q == StIdle) && !bus.serial_in && hist_q;
  assign timer_en   = (state_q == StStartChk) || (state_q == StData) || (state_q == StStopChk);

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (timer_en),
    .restart      (start_edge),
    .sample_strobe(strobe),
    .bit_index    (bit_index)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    framing_d = framing_q;

    if (bus.data_read && ready_q) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge) state_d = StStartChk;
      end
      StStartChk: begin
        if (strobe) begin
          if (bus.serial_in) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            framing_d = 1'b0;
          end
        end
      end
      StData: begin
        if (strobe) begin
          shift_d = {bus.serial_in, shift_q[DATA_BITS-1:1]};
          if (bit_index == IDX_W'(DATA_BITS)) state_d = StStopChk;
        end
      end
      StStopChk: begin
        if (strobe) begin
          if (bus.serial_in) begin
            state_d = StLoad;
          end else begin
            framing_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StLoad: begin
        rx_data_d = shift_q;
        ready_d   = 1'b1;
        // A read landing on the load cycle consumes the old byte, so no overrun.
        if (bus.data_read)  overrun_d = 1'b0;
        else if (ready_q)   overrun_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      hist_q    <= 1'b1;
      shift_q   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= bus.serial_in;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      framing_q <= framing_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = ready_q;
  assign bus.overrun_error = overrun_q;
  assign bus.framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed scoreboard bench for uart_rx_core at CLKS_PER_BIT=10, DATA_BITS=8.
module tb_uart_rx_core;
  import uart_rx_pkg::*;

  localparam int unsigned CPB = 10;
  localparam int unsigned DB  = 8;

  logic clk;
  logic n_rst;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ready;
    logic       ovr;
    logic       frm;
  } exp_t;

  exp_t sb_q[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic r, input logic o, input logic f);
    exp_t e;
    e = '{data: d, ready: r, ovr: o, frm: f};
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(e.data));
      chk({tag, "_ready"}, 32'(bus.data_ready), 32'(e.ready));
      chk({tag, "_overrun"}, 32'(bus.overrun_error), 32'(e.ovr));
      chk({tag, "_framing"}, 32'(bus.framing_error), 32'(e.frm));
    end
  endtask

  task automatic idle(input int n);
    bus.serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse(input string tag);
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
    chk({tag, "_ready_clr"}, 32'(bus.data_ready), 32'd0);
    chk({tag, "_ovr_clr"}, 32'(bus.overrun_error), 32'd0);
  endtask

  // Iteration i drives the value seen at posedge E+i; checks at i see state after E+i-1.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int read_cyc,
                            input bit lat_chk, input bit frm_chk, input int rst_cyc);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      if (lat_chk && i == 96) chk("latency_e95", 32'(bus.data_ready), 32'd0);
      if (lat_chk && i == 97) chk("latency_e96", 32'(bus.data_ready), 32'd1);
      if (frm_chk && i == 5) chk("frm_before_start_sample", 32'(bus.framing_error), 32'd1);
      if (frm_chk && i == 6) chk("frm_at_start_sample", 32'(bus.framing_error), 32'd0);
      if (rst_cyc >= 0 && i == rst_cyc) begin
        n_rst = 1'b0;
        #1;
        chk("rst_mid_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_mid_ready", 32'(bus.data_ready), 32'd0);
        chk("rst_mid_overrun", 32'(bus.overrun_error), 32'd0);
        chk("rst_mid_framing", 32'(bus.framing_error), 32'd0);
      end
      if (rst_cyc >= 0 && i == rst_cyc + 5) n_rst = 1'b1;
      bus.serial_in = bits[i/CPB];
      bus.data_read = (i == read_cyc);
      @(negedge clk);
    end
    bus.data_read = 1'b0;
    bus.serial_in = 1'b1;
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset_ready", 32'(bus.data_ready), 32'd0);
    chk("reset_overrun", 32'(bus.overrun_error), 32'd0);
    chk("reset_framing", 32'(bus.framing_error), 32'd0);
    n_rst = 1'b1;
    idle(5);

    // Good frame with latency probe
    push(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, -1, 1'b1, 1'b0, -1);
    pop_check("a5");
    read_pulse("rd_a5");
    idle(5);

    // Three-cycle glitch is a false start
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    pop_check("glitch");
    push(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, 1'b0, 1'b0, -1);
    pop_check("3c");

    // Bad stop bit leaves data and ready alone
    push(8'h3C, 1'b1, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, -1, 1'b0, 1'b0, -1);
    idle(20);
    pop_check("55_badstop");
    read_pulse("rd_3c");
    push(8'h0F, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, -1, 1'b0, 1'b1, -1);
    pop_check("0f");
    read_pulse("rd_0f");
    idle(5);

    // Back-to-back frames without a read -> overrun
    push(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, -1);
    pop_check("11");
    push(8'h22, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b0, 1'b0, -1);
    pop_check("22_overrun");
    read_pulse("rd_22");
    idle(5);

    // Read coincident with the LOAD cycle of the second frame
    push(8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, -1, 1'b0, 1'b0, -1);
    pop_check("33");
    push(8'h44, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 96, 1'b0, 1'b0, -1);
    pop_check("44_read_on_load");

    // Reset in the middle of a frame
    push(8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 1'b0, 1'b0, 40);
    pop_check("ff_reset");
    idle(10);
    push(8'h81, 1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, -1, 1'b0, 1'b0, -1);
    pop_check("81");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive core directly downstream of the two-flop synchronizer.
- Consumes the already-synchronized serial line and detects the start bit.
- Samples each bit at mid-period, shifts in LSB-first data and checks the stop bit.
- Presents the received byte with ready, overrun and framing-error flags to the packet/control logic.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..1023.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset; asynchronous, active-low.
- serial_in  input  1  synchronized serial line; idle high.
- data_read  input  1  one-cycle pulse; consumer has taken rx_data.
- rx_data  output  DATA_BITS  last good byte received.
- data_ready  output  1  high while rx_data holds an unread byte.
- overrun_error  output  1  a new byte overwrote an unread byte.
- framing_error  output  1  the last frame had stop bit = 0.

Behaviour:
- Reset (async, n_rst=0):
  - rx_data=0, data_ready=0, overrun_error=0, framing_error=0.
  - FSM=IDLE, edge-detect history register=1, counters=0.
  - Reset asserted mid-frame aborts the frame; no flag or data survives.
- Start edge: in IDLE, a clk edge E where serial_in=0 and history=1 is the start edge. Falling edges outside IDLE are ignored.
- Sample points: HALF = CLKS_PER_BIT/2 (integer division). Bit k is sampled at clk edge E + HALF + k*CLKS_PER_BIT, where k=0 is start, k=1..DATA_BITS are data (LSB first), and k=DATA_BITS+1 is stop.
- FSM states:
  - IDLE -> START_CHK on start edge.
  - START_CHK: at sample k=0, serial_in=1 is a false start -> IDLE with no flag change. serial_in=0 -> DATA, and framing_error clears at this edge.
  - DATA: shift serial_in into shift register MSB-side at each data sample. After bit DATA_BITS -> STOP_CHK.
  - STOP_CHK: at the stop sample:
    - stop=1 -> LOAD.
    - stop=0 -> framing_error=1, rx_data and data_ready unchanged, -> IDLE.
  - LOAD: one cycle.
    - rx_data<=shift register, data_ready<=1.
    - If data_ready was already 1 and data_read is not asserted this cycle, overrun_error<=1.
    - -> IDLE.
- Latency: data_ready rises at edge E + HALF + (DATA_BITS+1)*CLKS_PER_BIT + 1.
- Back-to-back frames: IDLE is re-entered before the stop bit ends, so a start edge arriving immediately after the stop bit is caught.
- data_read: clears data_ready and overrun_error at the next edge.
  - If data_read coincides with LOAD, LOAD wins: data_ready=1, overrun not set, overrun_error cleared.
  - data_read with data_ready=0 has no effect.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It is first loaded so the initial strobe lands HALF cycles after E. It holds at 0 in IDLE.
- Bit index: counts 0..DATA_BITS+1 and never wraps within a frame.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START_CHK, DATA, STOP_CHK, LOAD);
  - default constants for CLKS_PER_BIT and DATA_BITS;
  - a function computing the counter width from CLKS_PER_BIT.
- Sub-module rx_bit_timer:
  - Inputs: clk, n_rst, enable, restart.
  - Outputs: sample_strobe, bit_index.
  - Implements the half-bit-offset sample timing; the FSM and shift register stay in the top level.

Test Plan (CLKS_PER_BIT=10, DATA_BITS=8):
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_data=0xA5, data_ready high at edge E+96, both error flags 0.
- serial_in low for 3 cycles then high (glitch) -> FSM returns to IDLE at E+5, all outputs unchanged, next valid frame 0x3C received correctly.
- Frame 0x55 with stop bit 0 -> framing_error=1, rx_data and data_ready unchanged. Next good frame 0x0F: framing_error clears at its start sample, data_ready=1.
- Two frames 0x11 then 0x22 with no data_read -> rx_data=0x22, data_ready=1, overrun_error=1. A data_read pulse then clears both flags next cycle.
- data_read pulsed on the exact LOAD cycle of the second frame -> data_ready=1, overrun_error=0.
- n_rst asserted at E+40 during frame 0xFF -> all outputs 0 immediately. After release, a frame 0x81 is received correctly.
